// File: rtl/sm2_sign_rs_pkg.sv
// Shared constants, FSM encoding and a small helper for the SM2 signature
// r/s stage.
package sm2_sign_rs_pkg;

    localparam int W = 256;

    localparam logic [W-1:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [W-1:0] SM2_N =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123;
    localparam logic [W-1:0] SM2_A =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFC;
    localparam logic [W-1:0] SM2_B =
        256'h28E9FA9E_9D9F5E34_4D5A9E4B_CF6509A7_F39789F5_15AB8F92_DDBCBD41_4D940E93;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RED    = 3'd1,
        ST_RCHK   = 3'd2,
        ST_INV    = 3'd3,
        ST_MUL_RD = 3'd4,
        ST_MUL_S  = 3'd5,
        ST_SCHK   = 3'd6,
        ST_HOLD   = 3'd7
    } state_t;

    // One conditional subtraction; enough whenever v < 2*m.
    function automatic logic [W-1:0] cond_sub(input logic [W-1:0] v, input logic [W-1:0] m);
        return (v >= m) ? v - m : v;
    endfunction

endpackage

// File: rtl/sm2_sign_rs_if.sv
// Bundle between the coordinate converter / controller and the r/s stage.
// Handshake: coord_done is a level "inputs valid" held by the producer until
// it is reset; x_in, e, k and d must be stable while it is high. done is a
// level "result valid" held until coord_done drops; r_out/s_out/retry are
// only meaningful while done=1 (r_out/s_out read as 0 otherwise). state is
// the live FSM state for observation only.
interface sm2_sign_rs_if;
    import sm2_sign_rs_pkg::*;

    logic         coord_done;
    logic [W-1:0] x_in;
    logic [W-1:0] e;
    logic [W-1:0] k;
    logic [W-1:0] d;
    logic [W-1:0] r_out;
    logic [W-1:0] s_out;
    logic         done;
    logic         retry;
    state_t       state;

    modport master (
        output coord_done, x_in, e, k, d,
        input  r_out, s_out, done, retry, state
    );

    modport slave (
        input  coord_done, x_in, e, k, d,
        output r_out, s_out, done, retry, state
    );

endinterface

// File: rtl/add_mod.sv
// Combinational modular addition; both inputs expected below m.
module add_mod
    import sm2_sign_rs_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] y
);

    logic [W:0] sum;
    logic [W:0] red;

    // Add with carry, then fold back once if the sum reached m.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        red = sum - {1'b0, m};
        y   = (sum >= {1'b0, m}) ? red[W-1:0] : sum[W-1:0];
    end

endmodule

// File: rtl/inv_mod.sv
// Sequential modular inverse (binary extended Euclid, one step per cycle).
// Started by pulsing rst_n low with a/m stable; done rises with y = a^-1 mod m.
// A non-invertible a (e.g. 0) still terminates, with y = 0.
module inv_mod
    import sm2_sign_rs_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] m,
    output logic [W-1:0] y,
    output logic         done
);

    logic         loaded;
    logic [W-1:0] u, v, x1, x2;

    function automatic logic [W-1:0] half_mod(input logic [W-1:0] x, input logic [W-1:0] md);
        logic [W:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
        return s[W:1];
    endfunction

    function automatic logic [W-1:0] dif_mod(input logic [W-1:0] p, input logic [W-1:0] q,
                                             input logic [W-1:0] md);
        return (p >= q) ? p - q : p - q + md;
    endfunction

    // Load operands after reset release, then iterate until u or v hits 1 (or 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded <= 1'b0;
            done   <= 1'b0;
            y      <= '0;
            u      <= '0;
            v      <= '0;
            x1     <= '0;
            x2     <= '0;
        end else if (!loaded) begin
            u      <= a;
            v      <= m;
            x1     <= W'(1);
            x2     <= '0;
            loaded <= 1'b1;
        end else if (!done) begin
            if (u == W'(1) || v == W'(1) || u == '0 || v == '0) begin
                done <= 1'b1;
                y    <= (u == W'(1)) ? x1 : ((v == W'(1)) ? x2 : '0);
            end else if (!u[0]) begin
                u  <= u >> 1;
                x1 <= half_mod(x1, m);
            end else if (!v[0]) begin
                v  <= v >> 1;
                x2 <= half_mod(x2, m);
            end else if (u >= v) begin
                u  <= u - v;
                x1 <= dif_mod(x1, x2, m);
            end else begin
                v  <= v - u;
                x2 <= dif_mod(x2, x1, m);
            end
        end
    end

endmodule

// File: rtl/sm2_sign_rs_mul_mod_n.sv
// Bit-serial modular multiplier y = a*b mod N (MSB first, one bit per cycle).
// Started by pulsing rst_n low with a/b stable; done rises with the product.
module mul_mod_n
    import sm2_sign_rs_pkg::*;
#(
    parameter logic [W-1:0] N = SM2_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         done
);

    logic         loaded;
    logic [8:0]   cnt;
    logic [W-1:0] sh;
    logic [W-1:0] acc;
    logic [W-1:0] acc_nxt;
    logic [W:0]   dbl;
    logic [W:0]   dbl_r;
    logic [W:0]   add;
    logic [W:0]   add_r;

    // Horner step: acc = 2*acc (+ b if the current bit of a is set), each mod N.
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_r   = (dbl >= {1'b0, N}) ? dbl - {1'b0, N} : dbl;
        add     = dbl_r + {1'b0, b};
        add_r   = (add >= {1'b0, N}) ? add - {1'b0, N} : add;
        acc_nxt = sh[W-1] ? add_r[W-1:0] : dbl_r[W-1:0];
    end

    // Load, run W steps, then hold the result with done high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded <= 1'b0;
            done   <= 1'b0;
            y      <= '0;
            cnt    <= '0;
            sh     <= '0;
            acc    <= '0;
        end else if (!loaded) begin
            acc    <= '0;
            sh     <= a;
            cnt    <= 9'(W);
            loaded <= 1'b1;
        end else if (!done) begin
            if (cnt == '0) begin
                done <= 1'b1;
                y    <= acc;
            end else begin
                acc <= acc_nxt;
                sh  <= sh << 1;
                cnt <= cnt - 9'd1;
            end
        end
    end

endmodule

// File: rtl/sub_mod.sv
// Combinational modular subtraction; both inputs expected below m.
module sub_mod
    import sm2_sign_rs_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] y
);

    // Borrow case wraps mod 2^W, so adding m lands on the right residue.
    always_comb begin
        y = (a >= b) ? a - b : a - b + m;
    end

endmodule

// File: rtl/sm2_sign_rs.sv
// SM2 signature final stage: r = (e + x1) mod n, s = (1+d)^-1 (k - r*d) mod n,
// with retry raised for r = 0, r + k = n or s = 0.
module sm2_sign_rs
    import sm2_sign_rs_pkg::*;
#(
    parameter logic [W-1:0] N = SM2_N
) (
    input  logic            clk,
    input  logic            rst_n,
    sm2_sign_rs_if.slave    bus
);

    state_t       state;
    logic [W-1:0] x_q, e_q, k_q, d_q;
    logic [W-1:0] r_q, dinv_q, t_q, s_q;
    logic [W-1:0] r_out_q, s_out_q;
    logic         done_q, retry_q;
    logic         inv_start, mul_start;

    logic [W-1:0] r_sum, rk_sum, d1, t_new;
    logic [W-1:0] inv_y, mul_y, mul_a, mul_b;
    logic         inv_done, mul_done;
    logic         inv_rst_n, mul_rst_n;

    // Submodules are started by a one-cycle reset pulse from a flop, so the
    // gated reset is glitch-free and also follows the global reset.
    assign inv_rst_n = rst_n & ~inv_start;
    assign mul_rst_n = rst_n & ~mul_start;

    // One shared multiplier: r*d first, then dinv*t.
    assign mul_a = (state == ST_MUL_S) ? dinv_q : r_q;
    assign mul_b = (state == ST_MUL_S) ? t_q    : d_q;

    add_mod u_add_r  (.a(e_q),   .b(x_q),   .m(N), .y(r_sum));
    add_mod u_add_rk (.a(r_sum), .b(k_q),   .m(N), .y(rk_sum));
    add_mod u_add_d1 (.a(d_q),   .b(W'(1)), .m(N), .y(d1));
    sub_mod u_sub_t  (.a(k_q),   .b(mul_y), .m(N), .y(t_new));

    inv_mod u_inv (
        .clk  (clk),
        .rst_n(inv_rst_n),
        .a    (d1),
        .m    (N),
        .y    (inv_y),
        .done (inv_done)
    );

    mul_mod_n #(.N(N)) u_mul (
        .clk  (clk),
        .rst_n(mul_rst_n),
        .a    (mul_a),
        .b    (mul_b),
        .y    (mul_y),
        .done (mul_done)
    );

    assign bus.r_out = r_out_q;
    assign bus.s_out = s_out_q;
    assign bus.done  = done_q;
    assign bus.retry = retry_q;
    assign bus.state = state;

    // Control FSM with registered outputs; HOLD re-arms only when coord_done drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            x_q       <= '0;
            e_q       <= '0;
            k_q       <= '0;
            d_q       <= '0;
            r_q       <= '0;
            dinv_q    <= '0;
            t_q       <= '0;
            s_q       <= '0;
            r_out_q   <= '0;
            s_out_q   <= '0;
            done_q    <= 1'b0;
            retry_q   <= 1'b0;
            inv_start <= 1'b0;
            mul_start <= 1'b0;
        end else begin
            inv_start <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.coord_done) begin
                        x_q   <= bus.x_in;
                        e_q   <= bus.e;
                        k_q   <= bus.k;
                        d_q   <= bus.d;
                        state <= ST_RED;
                    end
                end
                ST_RED: begin
                    // x1 < p < 2n and e < 2^256 < 2n, so one subtract reduces both.
                    e_q   <= cond_sub(e_q, N);
                    x_q   <= cond_sub(x_q, N);
                    state <= ST_RCHK;
                end
                ST_RCHK: begin
                    r_q <= r_sum;
                    if (r_sum == '0 || rk_sum == '0) begin
                        retry_q <= 1'b1;
                        done_q  <= 1'b1;
                        r_out_q <= r_sum;
                        s_out_q <= '0;
                        state   <= ST_HOLD;
                    end else begin
                        inv_start <= 1'b1;
                        state     <= ST_INV;
                    end
                end
                ST_INV: begin
                    if (inv_done) begin
                        dinv_q    <= inv_y;
                        mul_start <= 1'b1;
                        state     <= ST_MUL_RD;
                    end
                end
                ST_MUL_RD: begin
                    if (mul_done) begin
                        t_q       <= t_new;
                        mul_start <= 1'b1;
                        state     <= ST_MUL_S;
                    end
                end
                ST_MUL_S: begin
                    if (mul_done) begin
                        s_q   <= mul_y;
                        state <= ST_SCHK;
                    end
                end
                ST_SCHK: begin
                    retry_q <= (s_q == '0);
                    done_q  <= 1'b1;
                    r_out_q <= r_q;
                    s_out_q <= s_q;
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!bus.coord_done) begin
                        done_q  <= 1'b0;
                        retry_q <= 1'b0;
                        r_out_q <= '0;
                        s_out_q <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm2_sign_rs.sv
// Self-checking bench for sm2_sign_rs: fixed vectors, retry corners,
// re-arm behaviour, mid-operation reset and a few random vectors.
module tb_sm2_sign_rs;
    import sm2_sign_rs_pkg::*;

    localparam int BUDGET = 6000;

    localparam logic [W-1:0] V1_D = 256'h3945208F7B2144B13F36E38AC6D39F95889393692860B51A42FB81EF4DF7C5B8;
    localparam logic [W-1:0] V1_K = 256'h59276E27D506861A16680F3AD9C02DCCEF3CC1FA3CDBE4CE6D54B80DEAC1BC21;
    localparam logic [W-1:0] V1_E = 256'hF0B43E94BA45ACCAACE692ED534382EB17E6AB5A19CE7B31F4486FDFC0D28640;
    localparam logic [W-1:0] V1_X = 256'h04EBFC718E8D1798620432268E77FEB6415E2EDE0E073C0F4F640ECD2E149A73;
    localparam logic [W-1:0] V1_R = 256'hF5A03B0648D2C4630EEAC513E1BB81A15944DA3827D5B74143AC7EACEEE720B3;
    localparam logic [W-1:0] V1_S = 256'hB1B6AA29DF212FD8763182BC0D421CA1BB9038FD1F7F42D4840B69C485BBC1AA;

    logic clk = 1'b0;
    logic rst_n;

    // Clock and reset
    always #5 clk = ~clk;

    sm2_sign_rs_if bus ();

    sm2_sign_rs dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_done_seen = 0;

    logic [W-1:0] exp_r_q[$];
    logic [W-1:0] exp_s_q[$];
    logic [W-1:0] exp_retry_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: wide-integer arithmetic, inverse via Fermat.
    function automatic logic [W-1:0] mulm(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [2*W-1:0] nn;
        nn = {{W{1'b0}}, SM2_N};
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p  = p % nn;
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] addm(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        s = s % {1'b0, SM2_N};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] powm(input logic [W-1:0] base, input logic [W-1:0] ex);
        logic [W-1:0] acc;
        acc = W'(1);
        for (int i = W - 1; i >= 0; i--) begin
            acc = mulm(acc, acc);
            if (ex[i]) acc = mulm(acc, base);
        end
        return acc;
    endfunction

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] e, input logic [W-1:0] k,
                         input logic [W-1:0] d, output logic [W-1:0] r, output logic [W-1:0] s,
                         output logic retry);
        logic [W-1:0] rk, dinv, t;
        r     = addm(e, x);
        rk    = addm(r, k);
        dinv  = powm(addm(d, W'(1)), SM2_N - W'(2));
        t     = addm(k, SM2_N - mulm(r, d));
        s     = mulm(dinv, t);
        retry = (r == '0) || (rk == '0) || (s == '0);
    endtask

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[W-33:0], 32'($urandom_range(32'hFFFF_FFFF, 0))};
        return v;
    endfunction

    // Scoreboard: compare on every rising edge of done
    logic         done_prev = 1'b0;
    logic [W-1:0] m_r, m_s, m_retry;
    always @(posedge clk) begin
        #1;
        if (bus.done && !done_prev) begin
            n_done_seen++;
            if (exp_r_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                m_r     = exp_r_q.pop_front();
                m_s     = exp_s_q.pop_front();
                m_retry = exp_retry_q.pop_front();
                check("retry", W'(bus.retry), m_retry);
                check("r_out", bus.r_out, m_r);
                if (m_retry == '0) check("s_out", bus.s_out, m_s);
            end
        end
        done_prev = bus.done;
    end

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus.done && cycles < BUDGET) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!bus.done) begin
            check("done_timeout", W'(bus.done), 1);
            if (exp_r_q.size() > 0) begin
                void'(exp_r_q.pop_front());
                void'(exp_s_q.pop_front());
                void'(exp_retry_q.pop_front());
            end
        end
    endtask

    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] e, input logic [W-1:0] k,
                         input logic [W-1:0] d);
        @(negedge clk);
        bus.x_in       = x;
        bus.e          = e;
        bus.k          = k;
        bus.d          = d;
        bus.coord_done = 1'b1;
    endtask

    task automatic release_and_check();
        @(negedge clk);
        bus.coord_done = 1'b0;
        @(posedge clk);
        #1;
        check("done_clear", W'(bus.done), 0);
        check("r_out_clear", bus.r_out, 0);
    endtask

    // Driver: push expectation, raise coord_done, wait, drop coord_done
    task automatic drive_vec(input logic [W-1:0] x, input logic [W-1:0] e, input logic [W-1:0] k,
                             input logic [W-1:0] d, input logic [W-1:0] er, input logic [W-1:0] es,
                             input logic eret, input int exp_lat);
        int cyc;
        exp_r_q.push_back(er);
        exp_s_q.push_back(es);
        exp_retry_q.push_back(W'(eret));
        apply(x, e, k, d);
        wait_done(cyc);
        if (exp_lat > 0) check("latency", W'(cyc), W'(exp_lat));
        release_and_check();
    endtask

    // Main sequence
    initial begin
        int lat;
        int drops;
        int seen;
        int cyc;
        logic [W-1:0] rx, re, rk, rd, mr, ms;
        logic mret;

        rst_n          = 1'b0;
        bus.coord_done = 1'b0;
        bus.x_in       = '0;
        bus.e          = '0;
        bus.k          = '0;
        bus.d          = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", W'(bus.done), 0);
        check("rst_retry", W'(bus.retry), 0);
        check("rst_r_out", bus.r_out, 0);
        check("rst_s_out", bus.s_out, 0);
        check("rst_state", W'(bus.state), W'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // GB/T 32918 example vector
        drive_vec(V1_X, V1_E, V1_K, V1_D, V1_R, V1_S, 1'b0, 0);
        // Small values
        drive_vec(W'(2), W'(1), W'(10), W'(1), W'(3), (SM2_N + W'(7)) >> 1, 1'b0, 0);
        // Reduction of both inputs giving r = 0: early retry after 3 cycles
        drive_vec(SM2_N - W'(5), SM2_N + W'(5), W'(10), W'(1), W'(0), W'(0), 1'b1, 3);
        // r + k = n
        drive_vec(W'(2), W'(1), SM2_N - W'(3), W'(1), W'(3), W'(0), 1'b1, 3);
        // s = 0 (k = r*d)
        drive_vec(W'(2), W'(1), W'(3), W'(1), W'(3), W'(0), 1'b1, 0);

        // Random vectors against the reference model
        for (int i = 0; i < 3; i++) begin
            rx = rand256() % SM2_P;
            re = rand256();
            rk = rand256() % (SM2_N - W'(1)) + W'(1);
            rd = rand256() % (SM2_N - W'(2)) + W'(1);
            model(rx, re, rk, rd, mr, ms, mret);
            drive_vec(rx, re, rk, rd, mr, ms, mret, 0);
        end

        // Re-arm: hold coord_done for about twice the latency, expect one run
        seen = n_done_seen;
        exp_r_q.push_back(W'(3));
        exp_s_q.push_back((SM2_N + W'(7)) >> 1);
        exp_retry_q.push_back(W'(0));
        apply(W'(2), W'(1), W'(10), W'(1));
        wait_done(lat);
        drops = 0;
        for (int i = 0; i < lat + 4; i++) begin
            @(posedge clk);
            #1;
            if (!bus.done) drops++;
        end
        check("rearm_done_held", W'(drops), 0);
        check("rearm_single_run", W'(n_done_seen), W'(seen + 1));
        release_and_check();
        drive_vec(W'(2), W'(1), W'(10), W'(1), W'(3), (SM2_N + W'(7)) >> 1, 1'b0, 0);
        check("rearm_second_run", W'(n_done_seen), W'(seen + 2));

        // Reset during INV aborts with no visible result
        apply(V1_X, V1_E, V1_K, V1_D);
        cyc = 0;
        while (bus.state != ST_INV && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reach_inv", W'(bus.state), W'(ST_INV));
        @(negedge clk);
        rst_n = 1'b0;
        bus.coord_done = 1'b0;
        #1;
        check("abort_done", W'(bus.done), 0);
        check("abort_retry", W'(bus.retry), 0);
        check("abort_r_out", bus.r_out, 0);
        check("abort_s_out", bus.s_out, 0);
        check("abort_state", W'(bus.state), W'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        drive_vec(V1_X, V1_E, V1_K, V1_D, V1_R, V1_S, 1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", W'(exp_r_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
